// File: rtl/binary_to_gray_pkg.sv
// Shared definitions for the binary/Gray converter family.
// Helpers work on 32-bit values; callers zero-extend narrower operands.
package binary_to_gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits from the MSB down to it.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
    for (int k = MAX_WIDTH - 2; k >= 0; k--) begin
      bin[k] = bin[k+1] ^ gray[k];
    end
    return bin;
  endfunction

endpackage

// File: rtl/binary_to_gray_if.sv
// Bundle of the converter's data/qualifier signals.
// check_err exists only when BINARY_TO_GRAY_CHECK_EN is defined.
interface binary_to_gray_if
  import binary_to_gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] bin_in;
  logic [WIDTH-1:0] gray_comb;
  logic             out_valid;
  logic [WIDTH-1:0] gray_out;
`ifdef BINARY_TO_GRAY_CHECK_EN
  logic             check_err;
`endif

  modport master (
    output in_valid,
    output bin_in,
    input  gray_comb,
    input  out_valid,
`ifdef BINARY_TO_GRAY_CHECK_EN
    input  check_err,
`endif
    input  gray_out
  );

  modport slave (
    input  in_valid,
    input  bin_in,
    output gray_comb,
    output out_valid,
`ifdef BINARY_TO_GRAY_CHECK_EN
    output check_err,
`endif
    output gray_out
  );

endinterface

// File: rtl/binary_to_gray_g2b.sv
// gray_to_binary: combinational Gray-to-binary decoder, reusable by
// any consumer of Gray-coded pointers.
module gray_to_binary
  import binary_to_gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  assign bin_o = WIDTH'(gray2bin(MAX_WIDTH'(gray_i)));

endmodule

// File: rtl/binary_to_gray.sv
// Registered binary-to-Gray converter with a combinational tap.
// Define BINARY_TO_GRAY_CHECK_EN to add the inverse-decode self check.
module binary_to_gray
  import binary_to_gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  binary_to_gray_if.slave  bus
);

  logic [WIDTH-1:0] gray_s;
  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] gray_q;
  logic             valid_d;
  logic             valid_q;

  assign gray_s        = WIDTH'(bin2gray(MAX_WIDTH'(bus.bin_in)));
  assign bus.gray_comb = gray_s;

  always_comb begin
    gray_d  = gray_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      gray_d  = gray_s;
      valid_d = 1'b1;
    end else begin
      gray_d  = gray_q;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      gray_q  <= gray_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gray_out  = gray_q;
  assign bus.out_valid = valid_q;

`ifdef BINARY_TO_GRAY_CHECK_EN
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] dec_s;

  always_comb begin
    bin_d = bin_q;
    if (bus.in_valid) begin
      bin_d = bus.bin_in;
    end else begin
      bin_d = bin_q;
    end
  end

  // Keeps the binary source alongside gray_q so the decode can be cross-checked.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= {WIDTH{1'b0}};
    end else begin
      bin_q <= bin_d;
    end
  end

  gray_to_binary #(.WIDTH(WIDTH)) u_dec (
    .gray_i (gray_q),
    .bin_o  (dec_s)
  );

  assign bus.check_err = valid_q & (dec_s != bin_q);
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// Scoreboard bench for binary_to_gray (WIDTH 4 main, plus WIDTH 1 and 8).
// Reference Gray values come from the reflected-sequence construction.
module tb_binary_to_gray;

  logic clk = 1'b0;
  logic rst;

  binary_to_gray_if #(.WIDTH(4)) if4 ();
  binary_to_gray_if #(.WIDTH(1)) if1 ();
  binary_to_gray_if #(.WIDTH(8)) if8 ();

  binary_to_gray #(.WIDTH(4)) dut  (.clk(clk), .rst(rst), .bus(if4));
  binary_to_gray #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  binary_to_gray #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  always #5 clk = ~clk;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] seen[$];

`ifdef BINARY_TO_GRAY_CHECK_EN
  localparam int N_RAND = 1000;
  localparam bit MIXED  = 1'b0;
`else
  localparam int N_RAND = 300;
  localparam bit MIXED  = 1'b1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reflected Gray code: the upper half of a w-bit sequence mirrors the lower half with the MSB set.
  function automatic logic [31:0] ref_gray(input int w, input logic [31:0] n);
    longint unsigned m;
    longint unsigned half;
    logic [31:0]     r;
    r = 32'd0;
    m = longint'(n);
    for (int b = w; b >= 1; b--) begin
      half = 64'd1 << (b - 1);
      if (m >= half) begin
        r = r | 32'(half);
        m = 2 * half - 1 - m;
      end
    end
    return r;
  endfunction

  task automatic step(input logic r, input logic v, input logic [3:0] b);
    @(posedge clk);
    #1;
    rst          = r;
    if4.in_valid = v;
    if4.bin_in   = b;
    if (v && !r) exp_q.push_back(ref_gray(4, 32'(b)));
    #1;
    check("gray_comb", 32'(if4.gray_comb), ref_gray(4, 32'(b)));
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (if4.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("gray_out", 32'(if4.gray_out), e);
        seen.push_back(32'(if4.gray_out));
`ifdef BINARY_TO_GRAY_CHECK_EN
        check("check_err_clean", 32'(if4.check_err), 32'd0);
`endif
      end
    end
  end

  initial begin
    logic r;
    logic v;
`ifdef BINARY_TO_GRAY_CHECK_EN
    logic [3:0] tmp;
`endif
    rst          = 1'b1;
    if4.in_valid = 1'b1;
    if4.bin_in   = 4'd9;
    if1.in_valid = 1'b1;
    if1.bin_in   = 1'b0;
    if8.in_valid = 1'b1;
    if8.bin_in   = 8'd0;

    repeat (2) begin
      @(negedge clk);
      check("rst_gray_out", 32'(if4.gray_out), 32'd0);
      check("rst_out_valid", 32'(if4.out_valid), 32'd0);
      check("rst_gray_comb", 32'(if4.gray_comb), ref_gray(4, 32'd9));
    end

    // Full sweep including the 15 -> 0 wrap.
    seen.delete();
    for (int b = 0; b < 16; b++) step(1'b0, 1'b1, 4'(b));
    step(1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    settle();
    check("sweep_count", 32'(seen.size()), 32'd17);
    for (int i = 0; i + 1 < seen.size(); i++)
      check("one_bit_change", 32'($countones(seen[i] ^ seen[i+1])), 32'd1);

    // Hold when in_valid is low.
    step(1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b0, 4'd10);
    settle();
    check("hold_gray_out", 32'(if4.gray_out), ref_gray(4, 32'd5));
    check("hold_out_valid", 32'(if4.out_valid), 32'd0);
    check("hold_gray_comb", 32'(if4.gray_comb), ref_gray(4, 32'd10));

    // Reset wins over a simultaneous valid input.
    step(1'b1, 1'b1, 4'd12);
    step(1'b0, 1'b0, 4'd12);
    @(negedge clk);
    check("midrst_gray_out", 32'(if4.gray_out), 32'd0);
    check("midrst_out_valid", 32'(if4.out_valid), 32'd0);
    step(1'b0, 1'b1, 4'd12);
    step(1'b0, 1'b0, 4'd12);
    settle();
    check("post_rst_gray_out", 32'(if4.gray_out), ref_gray(4, 32'd12));

    for (int i = 0; i < N_RAND; i++) begin
      r = MIXED && ($urandom_range(0, 15) == 0);
      v = !MIXED || ($urandom_range(0, 3) != 0);
      step(r, v, 4'($urandom_range(0, 15)));
    end
    step(1'b0, 1'b0, 4'd0);
    settle();

`ifdef BINARY_TO_GRAY_CHECK_EN
    step(1'b0, 1'b1, 4'd6);
    step(1'b0, 1'b0, 4'd0);
    @(negedge clk);
    #2;
    tmp = dut.gray_q ^ 4'b0001;
    force dut.gray_q = tmp;
    #1;
    check("check_err_forced", 32'(if4.check_err), 32'd1);
    release dut.gray_q;
`endif

    // Width corner cases.
    if1.bin_in = 1'b0;
    if8.bin_in = 8'hFF;
    settle();
    check("w1_gray0", 32'(if1.gray_out), ref_gray(1, 32'd0));
    check("w8_gray_ff", 32'(if8.gray_out), ref_gray(8, 32'hFF));
    if1.bin_in = 1'b1;
    if8.bin_in = 8'hA5;
    settle();
    check("w1_gray1", 32'(if1.gray_out), ref_gray(1, 32'd1));
    check("w8_gray_a5", 32'(if8.gray_out), ref_gray(8, 32'hA5));

    settle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
